// File: rtl/score_display.sv
// Multi-digit score renderer: serial binary-to-BCD (shift-add-3) feeding a glyph pixel matcher.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (least significant always drawn).
module score_display #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned SCORE_WIDTH = 14,
  parameter int unsigned BOX_W       = 4,
  parameter int unsigned BOX_H       = 4,
  parameter int unsigned GAP         = 4
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic [SCORE_WIDTH-1:0]  score,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  input  logic [9:0]              x_pos,
  input  logic [9:0]              y_pos,
  output logic                    pix_on,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    overflow,
  output logic                    done
);

  localparam int unsigned BcdW  = 4 * NUM_DIGITS;
  localparam int unsigned CntW  = (SCORE_WIDTH > 1) ? $clog2(SCORE_WIDTH) : 1;
  localparam int unsigned Pitch = 3 * BOX_W + GAP;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned v = 1;
    for (int unsigned i = 0; i < n; i++) v = v * 10;
    return v;
  endfunction

  localparam longint unsigned MaxVal = pow10(NUM_DIGITS) - 1;

  // Returns {left, mid, right} for one glyph row; 10..15 are blank.
  function automatic logic [2:0] glyph_row(input logic [3:0] n, input logic [2:0] r);
    logic [14:0] m;
    case (n)
      4'd0:    m = 15'b111_101_101_101_111;
      4'd1:    m = 15'b010_010_010_010_010;
      4'd2:    m = 15'b111_001_111_100_111;
      4'd3:    m = 15'b111_001_111_001_111;
      4'd4:    m = 15'b101_101_111_001_001;
      4'd5:    m = 15'b111_100_111_001_111;
      4'd6:    m = 15'b100_100_111_101_111;
      4'd7:    m = 15'b111_001_001_001_001;
      4'd8:    m = 15'b111_101_111_101_111;
      4'd9:    m = 15'b111_101_111_001_001;
      default: m = 15'b0;
    endcase
    return m[14 - 3 * int'(r) -: 3];
  endfunction

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  state_e                        state_q;
  logic [SCORE_WIDTH-1:0]        bin_q;
  logic [BcdW-1:0]               work_q;
  logic [CntW-1:0]               cnt_q;
  logic                          ovf_pend_q;
  logic [BcdW-1:0]               adj;
  logic [BcdW+SCORE_WIDTH-1:0]   shifted;

  always_comb begin
    adj = work_q;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (work_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end
    shifted = {adj, bin_q} << 1;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= StIdle;
      load_ready <= 1'b1;
      done       <= 1'b0;
      overflow   <= 1'b0;
      bcd_out    <= '0;
      bin_q      <= '0;
      work_q     <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (load_valid && load_ready) begin
            if (64'(score) > MaxVal) begin
              bin_q      <= SCORE_WIDTH'(MaxVal);
              ovf_pend_q <= 1'b1;
            end else begin
              bin_q      <= score;
              ovf_pend_q <= 1'b0;
            end
            work_q     <= '0;
            cnt_q      <= '0;
            load_ready <= 1'b0;
            state_q    <= StShift;
          end
        end
        StShift: begin
          {work_q, bin_q} <= shifted;
          cnt_q           <= cnt_q + 1'b1;
          if (cnt_q == CntW'(SCORE_WIDTH - 1)) state_q <= StCommit;
        end
        StCommit: begin
          bcd_out    <= work_q;
          overflow   <= ovf_pend_q;
          done       <= 1'b1;
          load_ready <= 1'b1;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Pixel matcher: 11-bit sums keep origins near the right/bottom edge from wrapping.
  logic        pix_d;
  logic        in_rows;
  logic [10:0] dy;
  logic [2:0]  row;
  logic [3:0]  nib;
  logic [10:0] start;
  logic [10:0] dx;
  logic [1:0]  col;
  logic [2:0]  gr;
  logic        blank;
`ifdef LEADING_ZERO_BLANK_EN
  logic        lz;
`endif

  always_comb begin
    pix_d   = 1'b0;
    nib     = '0;
    start   = '0;
    dx      = '0;
    col     = '0;
    gr      = '0;
    blank   = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    lz      = 1'b1;
`endif
    in_rows = ({1'b0, DrawY} >= {1'b0, y_pos}) &&
              ({1'b0, DrawY} < {1'b0, y_pos} + 11'(5 * BOX_H));
    dy      = {1'b0, DrawY} - {1'b0, y_pos};
    row     = 3'd0;
    for (int r = 1; r < 5; r++) begin
      if (dy >= 11'(r * int'(BOX_H))) row = 3'(r);
    end
    for (int d = 0; d < int'(NUM_DIGITS); d++) begin
      nib   = bcd_out[4*(int'(NUM_DIGITS) - 1 - d) +: 4];
      start = {1'b0, x_pos} + 11'(d * int'(Pitch));
      dx    = {1'b0, DrawX} - start;
      col   = (dx >= 11'(2 * BOX_W)) ? 2'd2 : (dx >= 11'(BOX_W)) ? 2'd1 : 2'd0;
      gr    = glyph_row(nib, row);
      blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      blank = lz && (nib == 4'd0) && (d != int'(NUM_DIGITS) - 1);
      if (nib != 4'd0) lz = 1'b0;
`endif
      if (in_rows && !blank && ({1'b0, DrawX} >= start) &&
          ({1'b0, DrawX} < start + 11'(3 * BOX_W)) && gr[2'd2 - col]) begin
        pix_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) pix_on <= 1'b0;
    else          pix_on <= pix_d;
  end

endmodule

// File: tb/tb_score_display.sv
// Directed self-checking bench for score_display: conversion timing, saturation, glyph geometry.
module tb_score_display;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [13:0] score;
  logic        load_valid;
  logic        load_ready;
  logic [9:0]  DrawX, DrawY, x_pos, y_pos;
  logic        pix_on;
  logic [15:0] bcd_out;
  logic        overflow;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  score_display dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .score      (score),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .pix_on     (pix_on),
    .bcd_out    (bcd_out),
    .overflow   (overflow),
    .done       (done)
  );

  // Pixel table: origin x/y, draw x/y, expected pix_on; value 1234 committed.
  localparam int NPts = 16;
  localparam int GOX[NPts] = '{100, 100, 100, 100, 100, 100, 100, 100, 100, 100, 100, 100, 100,
                               1010, 1020, 100};
  localparam int GOY[NPts] = '{50, 50, 50, 50, 50, 50, 50, 50, 50, 50, 50, 50, 50, 0, 0, 1015};
  localparam int GDX[NPts] = '{105, 101, 113, 117, 104, 100, 104, 149, 153, 157, 99, 133, 141,
                               1015, 44, 105};
  localparam int GDY[NPts] = '{52, 52, 52, 50, 69, 69, 70, 58, 62, 62, 52, 54, 54, 0, 0, 2};
  localparam int GEX[NPts] = '{1, 0, 0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0};

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Loads one score and waits (bounded) for its commit; returns just after the commit edge.
  task automatic load_score(input logic [13:0] v);
    int n = 0;
    score      = v;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL load_done(%0d): done=%b required 1 within 40 cycles", v, done);
    end
  endtask

  task automatic test_reset();
    logic seen = 1'b0;
    Reset_n = 1'b0;
    repeat (2) tick();
    n_cmp += 5;
    if (load_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", load_ready); end
    if (pix_on !== 1'b0) begin n_bad++; $display("FAIL rst_pix: got %b want 0", pix_on); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    if (bcd_out !== 16'h0000) begin n_bad++; $display("FAIL rst_bcd: got %h want 0000", bcd_out); end
    Reset_n    = 1'b1;
    score      = 14'd1234;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    n_cmp++;
    if (load_ready !== 1'b0) begin n_bad++; $display("FAIL mid_accept: got %b want 0", load_ready); end
    repeat (4) tick();
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    n_cmp += 2;
    if (load_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_ready: got %b want 1", load_ready); end
    if (bcd_out !== 16'h0000) begin n_bad++; $display("FAIL mid_rst_bcd: got %h want 0000", bcd_out); end
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) seen = 1'b1;
      tick();
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL mid_rst_done: got pulse %b want 0", seen); end
  endtask

  task automatic test_convert();
    int bad_busy = 0;
    score      = 14'd1234;
    load_valid = 1'b1;
    tick();
    score = 14'd4321;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (done !== 1'b0 || load_ready !== 1'b0) bad_busy++;
    end
    load_valid = 1'b0;
    n_cmp++;
    if (bad_busy != 0) begin
      n_bad++;
      $display("FAIL conv_busy: got %0d bad cycles want 0", bad_busy);
    end
    tick();
    n_cmp += 4;
    if (done !== 1'b1) begin n_bad++; $display("FAIL conv_done_t15: got %b want 1", done); end
    if (bcd_out !== 16'h1234) begin n_bad++; $display("FAIL conv_bcd: got %h want 1234", bcd_out); end
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL conv_ovf: got %b want 0", overflow); end
    if (load_ready !== 1'b1) begin n_bad++; $display("FAIL conv_ready: got %b want 1", load_ready); end
    tick();
    n_cmp += 2;
    if (done !== 1'b0) begin n_bad++; $display("FAIL conv_done_pulse: got %b want 0", done); end
    if (bcd_out !== 16'h1234) begin n_bad++; $display("FAIL conv_hold: got %h want 1234", bcd_out); end
  endtask

  task automatic test_overflow();
    load_score(14'd12000);
    n_cmp += 2;
    if (bcd_out !== 16'h9999) begin n_bad++; $display("FAIL sat_bcd: got %h want 9999", bcd_out); end
    if (overflow !== 1'b1) begin n_bad++; $display("FAIL sat_ovf: got %b want 1", overflow); end
    load_score(14'd5);
    n_cmp += 2;
    if (bcd_out !== 16'h0005) begin n_bad++; $display("FAIL five_bcd: got %h want 0005", bcd_out); end
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL five_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_geometry();
    load_score(14'd1234);
    for (int i = 0; i < NPts; i++) begin
      x_pos = 10'(GOX[i]);
      y_pos = 10'(GOY[i]);
      DrawX = 10'(GDX[i]);
      DrawY = 10'(GDY[i]);
      tick();
      n_cmp++;
      if (pix_on !== 1'(GEX[i])) begin
        n_bad++;
        $display("FAIL pix(%0d,%0d org %0d,%0d): got %b want %0d", GDX[i], GDY[i], GOX[i], GOY[i],
                 pix_on, GEX[i]);
      end
    end
    // Output must lag the inputs by exactly one edge.
    x_pos = 10'd100;
    y_pos = 10'd50;
    DrawX = 10'd105;
    DrawY = 10'd52;
    tick();
    DrawX = 10'd101;
    #2;
    n_cmp++;
    if (pix_on !== 1'b1) begin n_bad++; $display("FAIL pix_latency_hold: got %b want 1", pix_on); end
    tick();
    n_cmp++;
    if (pix_on !== 1'b0) begin n_bad++; $display("FAIL pix_latency_next: got %b want 0", pix_on); end
  endtask

  task automatic test_back_to_back();
    int bad_busy = 0;
    load_score(14'd7);
    n_cmp++;
    if (bcd_out !== 16'h0007) begin n_bad++; $display("FAIL b2b_first: got %h want 0007", bcd_out); end
    score      = 14'd9999;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    n_cmp++;
    if (load_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_accept: got %b want 0", load_ready); end
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (done !== 1'b0 || bcd_out !== 16'h0007) bad_busy++;
    end
    n_cmp++;
    if (bad_busy != 0) begin
      n_bad++;
      $display("FAIL b2b_busy: got %0d bad cycles want 0", bad_busy);
    end
    tick();
    n_cmp += 3;
    if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_done: got %b want 1", done); end
    if (bcd_out !== 16'h9999) begin n_bad++; $display("FAIL b2b_bcd: got %h want 9999", bcd_out); end
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL b2b_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_leading_zero();
    logic lead;
`ifdef LEADING_ZERO_BLANK_EN
    lead = 1'b0;
`else
    lead = 1'b1;
`endif
    x_pos = 10'd0;
    y_pos = 10'd0;
    load_score(14'd5);
    DrawX = 10'd1;  DrawY = 10'd1;  tick();
    n_cmp++;
    if (pix_on !== lead) begin n_bad++; $display("FAIL lz5_d0: got %b want %b", pix_on, lead); end
    DrawX = 10'd49; tick();
    n_cmp++;
    if (pix_on !== 1'b1) begin n_bad++; $display("FAIL lz5_d3: got %b want 1", pix_on); end
    load_score(14'd0);
    DrawX = 10'd49; tick();
    n_cmp++;
    if (pix_on !== 1'b1) begin n_bad++; $display("FAIL lz0_d3: got %b want 1", pix_on); end
    DrawX = 10'd1;  tick();
    n_cmp++;
    if (pix_on !== lead) begin n_bad++; $display("FAIL lz0_d0: got %b want %b", pix_on, lead); end
    load_score(14'd50);
    DrawX = 10'd17; tick();
    n_cmp++;
    if (pix_on !== lead) begin n_bad++; $display("FAIL lz50_d1: got %b want %b", pix_on, lead); end
    DrawX = 10'd33; tick();
    n_cmp++;
    if (pix_on !== 1'b1) begin n_bad++; $display("FAIL lz50_d2: got %b want 1", pix_on); end
    DrawX = 10'd49; tick();
    n_cmp++;
    if (pix_on !== 1'b1) begin n_bad++; $display("FAIL lz50_d3: got %b want 1", pix_on); end
  endtask

  initial begin
    Reset_n    = 1'b0;
    score      = '0;
    load_valid = 1'b0;
    DrawX      = '0;
    DrawY      = '0;
    x_pos      = '0;
    y_pos      = '0;
    test_reset();
    test_convert();
    test_overflow();
    test_geometry();
    test_back_to_back();
    test_leading_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
